// File: rtl/display_modes_pkg.sv
// Timing constant sets for standard video modes, plus the position-window helper
// used by the timing generator.
package display_modes;

  typedef struct packed {
    int unsigned h_res;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_res;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        h_pol;
    logic        v_pol;
  } mode_t;

  localparam mode_t MODE_480P  = '{32'd640,  32'd16,  32'd96,  32'd48,
                                   32'd480,  32'd10,  32'd2,   32'd33, 1'b0, 1'b0};
  localparam mode_t MODE_600P  = '{32'd800,  32'd40,  32'd128, 32'd88,
                                   32'd600,  32'd1,   32'd4,   32'd23, 1'b1, 1'b1};
  localparam mode_t MODE_720P  = '{32'd1280, 32'd110, 32'd40,  32'd220,
                                   32'd720,  32'd5,   32'd5,   32'd20, 1'b1, 1'b1};
  localparam mode_t MODE_1080P = '{32'd1920, 32'd88,  32'd44,  32'd148,
                                   32'd1080, 32'd4,   32'd5,   32'd36, 1'b1, 1'b1};

  // Half-open window test on signed 16-bit positions: sta <= pos < fin.
  function automatic logic in_span(input logic signed [15:0] pos,
                                   input logic signed [15:0] sta,
                                   input logic signed [15:0] fin);
    return (pos >= sta) && (pos < fin);
  endfunction

endpackage

// File: rtl/display_timings.sv
// Video timing generator: signed screen position counters with sync, data-enable
// and line/frame strobes aligned to the position of the same cycle.
module display_timings
  import display_modes::*;
#(
  parameter int   H_RES  = 640,
  parameter int   V_RES  = 480,
  parameter int   H_FP   = 16,
  parameter int   H_SYNC = 96,
  parameter int   H_BP   = 48,
  parameter int   V_FP   = 10,
  parameter int   V_SYNC = 2,
  parameter int   V_BP   = 33,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_locked,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic               o_frame,
  output logic               o_line,
  output logic signed [15:0] o_sx,
  output logic signed [15:0] o_sy
);

  // Blanking sits at negative coordinates so the active area starts at (0,0).
  localparam logic signed [15:0] H_STA  = 16'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [15:0] HS_STA = 16'(-(H_SYNC + H_BP));
  localparam logic signed [15:0] HS_END = 16'(-H_BP);
  localparam logic signed [15:0] HA_END = 16'(H_RES - 1);
  localparam logic signed [15:0] V_STA  = 16'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [15:0] VS_STA = 16'(-(V_SYNC + V_BP));
  localparam logic signed [15:0] VS_END = 16'(-V_BP);
  localparam logic signed [15:0] VA_END = 16'(V_RES - 1);

  logic signed [15:0] sx_d, sx_q, sy_d, sy_q;
  logic               hs_d, hs_q, vs_d, vs_q, de_d, de_q, line_d, line_q, frame_d, frame_q;
  logic               en_s;

  assign en_s = i_locked & ~i_rst;

  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (i_locked) begin
      if (sx_q == HA_END) begin
        sx_d = H_STA;
        sy_d = (sy_q == VA_END) ? V_STA : sy_q + 16'sd1;
      end else begin
        sx_d = sx_q + 16'sd1;
      end
    end else begin
      sx_d = sx_q;
    end
    // Decode from the next position so registered flags line up with the counters.
    hs_d    = in_span(sx_d, HS_STA, HS_END) ? H_POL : ~H_POL;
    vs_d    = in_span(sy_d, VS_STA, VS_END) ? V_POL : ~V_POL;
    de_d    = (sx_d >= 16'sd0) && (sy_d >= 16'sd0);
    line_d  = (sx_d == H_STA);
    frame_d = (sx_d == H_STA) && (sy_d == V_STA);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sx_q    <= H_STA;
      sy_q    <= V_STA;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b1;
      frame_q <= 1'b1;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  // Strobes are qualified so a stalled or resetting counter never repeats a pulse.
  assign o_line  = line_q & en_s;
  assign o_frame = frame_q & en_s;
  assign o_hs    = hs_q;
  assign o_vs    = vs_q;
  assign o_de    = de_q;
  assign o_sx    = sx_q;
  assign o_sy    = sy_q;

endmodule

// File: doc/display_timings.md
DISPLAY_TIMINGS -- requirements
Module: display_timings

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset; the clock port SHALL be named i_clk (pixel clock) and the reset port i_rst.
REQ-002 Parameters (name, default, meaning), one per line:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- H_POL, 0, hsync active level
- V_POL, 0, vsync active level
REQ-003 Ports (name, direction, width, meaning), one per line:
- i_clk, in, 1, pixel clock
- i_rst, in, 1, synchronous active-high reset
- i_locked, in, 1, pixel-clock PLL locked; counting enable
- o_hs, out, 1, horizontal sync at H_POL when active
- o_vs, out, 1, vertical sync at V_POL when active
- o_de, out, 1, data enable, high in active area
- o_frame, out, 1, one-cycle pulse at start of frame
- o_line, out, 1, one-cycle pulse at start of each line
- o_sx, out, 16 signed, horizontal position
- o_sy, out, 16 signed, vertical position

Function
REQ-004 Derived constants: H_STA = -(H_FP+H_SYNC+H_BP); HS_STA = H_STA+H_FP; HS_END = HS_STA+H_SYNC; HA_END = H_RES-1. V_STA, VS_STA, VS_END and VA_END are derived the same way from the vertical parameters.
REQ-005 o_sx SHALL count H_STA..HA_END, incrementing by 1 each enabled cycle; after HA_END it SHALL wrap to H_STA.
REQ-006 o_sy SHALL increment only on cycles where o_sx wraps; after VA_END it SHALL wrap to V_STA.
REQ-007 A cycle is enabled when i_locked=1 and i_rst=0. While i_locked=0, all registers SHALL hold their current values.
REQ-008 o_hs SHALL equal H_POL when HS_STA <= o_sx < HS_END, and ~H_POL otherwise.
REQ-009 o_vs SHALL equal V_POL when VS_STA <= o_sy < VS_END, and ~V_POL otherwise.
REQ-010 o_de SHALL be 1 exactly when o_sx >= 0 and o_sy >= 0.
REQ-011 o_line SHALL be 1 exactly when o_sx == H_STA.
REQ-012 o_frame SHALL be 1 exactly when o_sx == H_STA and o_sy == V_STA.
REQ-013 Every output SHALL correspond to the o_sx/o_sy values of the same cycle, with zero relative latency.
REQ-014 o_line and o_frame SHALL be forced to 0 while i_locked=0, so that a stalled state does not produce repeated pulses.
REQ-015 All position comparisons SHALL be signed 16-bit; totals up to 4095 per axis SHALL be supported without overflow.
REQ-016 Frame length SHALL be (H_RES-H_STA) x (V_RES-V_STA) enabled cycles.

Reset
REQ-017 While i_rst=1 the block SHALL set o_sx=H_STA, o_sy=V_STA, o_hs=~H_POL, o_vs=~V_POL, o_de=0, o_line=0 and o_frame=0.
REQ-018 Reset SHALL take priority over i_locked.
REQ-019 Reset asserted mid-frame SHALL return the counters to the start on the next clock edge.
REQ-020 On the first enabled cycle after reset, o_frame and o_line SHALL be 1.

Structure
REQ-021 The block SHALL be self-contained, with no sub-modules.
REQ-022 Standard mode timing constant sets (480p, 600p, 720p, 1080p) SHALL live in a shared display_modes package; the block SHALL take its values only via parameters.

Verification (640x480 defaults unless stated)
REQ-023 Release reset with i_locked=1: the first cycle shows sx=-160, sy=-45, frame=1, line=1, de=0; the next o_frame occurs exactly 420000 cycles later.
REQ-024 Hsync: o_hs=0 for sx -144..-49 (96 cycles), and o_hs=1 at sx=-145 and sx=-48.
REQ-025 Data enable: de=1 for 640x480=307200 cycles per frame; first de at (0,0), last de at (639,479), followed by a wrap to (-160,-45).
REQ-026 Drop i_locked for 50 cycles at sx=100, sy=200: sx/sy hold, line/frame remain 0, and counting resumes at sx=101.
REQ-027 Assert i_rst for 1 cycle at sx=300, sy=300: the next cycle shows the REQ-017 values, and a frame pulse follows on the first enabled cycle.
REQ-028 Re-parameterize to 1280x720 (110/40/220, 5/5/20, H_POL=V_POL=1): frame = 1650x750 = 1237500 cycles, o_hs=1 for 40 cycles per line, and o_vs=1 for 5 lines.
